// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage front end for the multdiv unit: latch one MULT/DIV, pulse start, wait for ready, emit one writeback.
// Latency: accept N, pulse N+1, ready sampled from N+3, writeback one cycle after ready; stalls upstream while busy.
module multdiv_issue_ctrl #(
   parameter int          TIMEOUT       = 64,
   parameter logic [4:0]  STATUS_REG    = 5'd30,
   parameter logic [31:0] MULT_EXC_CODE = 32'd4,
   parameter logic [31:0] DIV_EXC_CODE  = 32'd5
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        issue_valid,
   input  logic        issue_is_mult,
   input  logic [31:0] issue_opA,
   input  logic [31:0] issue_opB,
   input  logic [4:0]  issue_rd,
   input  logic        flush,
   output logic        issue_ready,
   output logic        stall,
   output logic [31:0] md_operandA,
   output logic [31:0] md_operandB,
   output logic        md_ctrl_MULT,
   output logic        md_ctrl_DIV,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   opa_q, opb_q, res_q;
   logic [4:0]    rd_q;
   logic          is_mult_q, exc_q;
   logic          accept, capture, timeout;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Ready is ignored at count 0: the multdiv unit may still show ready from the previous op.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      capture = 1'b0;
      timeout = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (issue_valid && !flush) begin
               accept  = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = flush ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (flush) begin
               state_d = S_IDLE;
            end else if ((cnt_q != '0) && md_resultRDY) begin
               capture = 1'b1;
               state_d = S_DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               timeout = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         opa_q     <= '0;
         opb_q     <= '0;
         rd_q      <= '0;
         is_mult_q <= 1'b0;
         res_q     <= '0;
         exc_q     <= 1'b0;
      end else begin
         if (accept) begin
            opa_q     <= issue_opA;
            opb_q     <= issue_opB;
            rd_q      <= issue_rd;
            is_mult_q <= issue_is_mult;
            exc_q     <= 1'b0;
         end
         if (capture) begin
            res_q <= md_result;
            exc_q <= md_exception;
         end else if (timeout) begin
            res_q <= '0;
            exc_q <= 1'b1;
         end
      end
   end

   assign md_operandA = opa_q;
   assign md_operandB = opb_q;

   always_comb begin
      issue_ready  = (state_q == S_IDLE);
      stall        = ((state_q == S_IDLE) && issue_valid) ||
                     (state_q == S_ISSUE) || (state_q == S_WAIT);
      md_ctrl_MULT = (state_q == S_ISSUE) && is_mult_q;
      md_ctrl_DIV  = (state_q == S_ISSUE) && !is_mult_q;
      wb_valid     = 1'b0;
      wb_rd        = '0;
      wb_data      = '0;
      // A flush landing in the writeback cycle still kills the write.
      if ((state_q == S_DONE) && !flush) begin
         if (exc_q) begin
            wb_valid = 1'b1;
            wb_rd    = STATUS_REG;
            wb_data  = is_mult_q ? MULT_EXC_CODE : DIV_EXC_CODE;
         end else if (rd_q != '0) begin
            wb_valid = 1'b1;
            wb_rd    = rd_q;
            wb_data  = res_q;
         end
      end
   end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Bench for multdiv_issue_ctrl: scenario tasks drive a hand-modelled multdiv unit; writebacks are scoreboarded.
module tb_multdiv_issue_ctrl;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        issue_valid, issue_is_mult, flush;
   logic [31:0] issue_opA, issue_opB;
   logic [4:0]  issue_rd;
   logic        issue_ready, stall;
   logic [31:0] md_operandA, md_operandB;
   logic        md_ctrl_MULT, md_ctrl_DIV;
   logic [31:0] md_result;
   logic        md_exception, md_resultRDY;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   wb_t sb[$];
   int  checks = 0;
   int  errors = 0;
   int  mult_pulses = 0;
   int  div_pulses = 0;

   always #5 clock = ~clock;

   multdiv_issue_ctrl dut (
      .clock(clock), .reset_n(reset_n),
      .issue_valid(issue_valid), .issue_is_mult(issue_is_mult),
      .issue_opA(issue_opA), .issue_opB(issue_opB), .issue_rd(issue_rd),
      .flush(flush), .issue_ready(issue_ready), .stall(stall),
      .md_operandA(md_operandA), .md_operandB(md_operandB),
      .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
      .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   // Writeback monitor: every beat must match the oldest expected entry.
   always @(negedge clock) begin
      wb_t e;
      if (reset_n === 1'b1) begin
         if (md_ctrl_MULT === 1'b1) mult_pulses++;
         if (md_ctrl_DIV === 1'b1) div_pulses++;
         if (wb_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL wb_unexpected: got rd=%0d data=%0d, required no write", wb_rd, wb_data);
            end else begin
               e = sb.pop_front();
               if (wb_rd !== e.rd || wb_data !== e.data) begin
                  errors++;
                  $display("FAIL wb_beat: got rd=%0d data=%0d, required rd=%0d data=%0d",
                           wb_rd, wb_data, e.rd, e.data);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic advance(input int n);
      repeat (n) tick();
   endtask

   // Presents one instruction for a single cycle; returns in the ISSUE cycle.
   task automatic issue(input logic m, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      issue_valid   = 1'b1;
      issue_is_mult = m;
      issue_opA     = a;
      issue_opB     = b;
      issue_rd      = rd;
      tick();
      issue_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      advance(3);
      checks++;
      if ({issue_ready, stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, required 10000", {issue_ready, stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid});
      end
      checks++;
      if (md_operandA !== 32'd0 || md_operandB !== 32'd0) begin
         errors++;
         $display("FAIL reset_operands: got %0d/%0d, required 0/0", md_operandA, md_operandB);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_mult_basic();
      int mp0 = mult_pulses;
      sb.push_back('{5'd3, 32'd42});
      issue(1'b1, 32'd7, 32'd6, 5'd3);
      checks++;
      if ({md_ctrl_MULT, md_ctrl_DIV, stall} !== 3'b101) begin
         errors++;
         $display("FAIL mult_pulse: got mult,div,stall=%b, required 101", {md_ctrl_MULT, md_ctrl_DIV, stall});
      end
      checks++;
      if (md_operandA !== 32'd7 || md_operandB !== 32'd6) begin
         errors++;
         $display("FAIL mult_operands: got %0d/%0d, required 7/6", md_operandA, md_operandB);
      end
      advance(11);
      checks++;
      if (stall !== 1'b1 || md_operandA !== 32'd7) begin
         errors++;
         $display("FAIL mult_wait_hold: got stall=%b opA=%0d, required 1/7", stall, md_operandA);
      end
      md_resultRDY = 1'b1; md_result = 32'd42; md_exception = 1'b0;
      tick();
      md_resultRDY = 1'b0;
      checks++;
      if ({wb_valid, stall} !== 2'b10 || wb_rd !== 5'd3 || wb_data !== 32'd42) begin
         errors++;
         $display("FAIL mult_done: got valid=%b stall=%b rd=%0d data=%0d, required 1 0 3 42",
                  wb_valid, stall, wb_rd, wb_data);
      end
      tick();
      checks++;
      if (issue_ready !== 1'b1 || (mult_pulses - mp0) != 1) begin
         errors++;
         $display("FAIL mult_end: got ready=%b pulses=%0d, required 1 and 1", issue_ready, mult_pulses - mp0);
      end
   endtask

   task automatic test_div_exception();
      sb.push_back('{5'd30, 32'd5});
      issue(1'b0, 32'd100, 32'd0, 5'd4);
      checks++;
      if ({md_ctrl_MULT, md_ctrl_DIV} !== 2'b01) begin
         errors++;
         $display("FAIL div_pulse: got mult,div=%b, required 01", {md_ctrl_MULT, md_ctrl_DIV});
      end
      advance(4);
      md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'hdead;
      tick();
      md_resultRDY = 1'b0; md_exception = 1'b0;
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd5) begin
         errors++;
         $display("FAIL div_exc: got valid=%b rd=%0d data=%0d, required 1 30 5", wb_valid, wb_rd, wb_data);
      end
      tick();
   endtask

   task automatic test_stale_ready();
      sb.push_back('{5'd5, 32'd12});
      md_resultRDY = 1'b1; md_result = 32'd999;
      issue(1'b1, 32'd3, 32'd4, 5'd5);
      tick();
      tick();
      md_resultRDY = 1'b0;
      checks++;
      if (stall !== 1'b1 || wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL stale_rdy: got stall=%b wb_valid=%b, required 1 0", stall, wb_valid);
      end
      advance(11);
      md_resultRDY = 1'b1; md_result = 32'd12;
      tick();
      md_resultRDY = 1'b0;
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== 32'd12) begin
         errors++;
         $display("FAIL stale_real: got valid=%b data=%0d, required 1 12", wb_valid, wb_data);
      end
      tick();
   endtask

   task automatic test_timeout();
      sb.push_back('{5'd30, 32'd5});
      issue(1'b0, 32'd8, 32'd2, 5'd6);
      advance(64);
      checks++;
      if (stall !== 1'b1 || wb_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: got stall=%b wb_valid=%b, required 1 0", stall, wb_valid);
      end
      tick();
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd5) begin
         errors++;
         $display("FAIL timeout_wb: got valid=%b rd=%0d data=%0d, required 1 30 5", wb_valid, wb_rd, wb_data);
      end
      tick();
      checks++;
      if (issue_ready !== 1'b1) begin
         errors++;
         $display("FAIL timeout_idle: got ready=%b, required 1", issue_ready);
      end
   endtask

   task automatic test_flush();
      issue(1'b1, 32'd5, 32'd5, 5'd7);
      advance(6);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (issue_ready !== 1'b1 || stall !== 1'b0) begin
         errors++;
         $display("FAIL flush_wait: got ready=%b stall=%b, required 1 0", issue_ready, stall);
      end
      md_resultRDY = 1'b1; md_result = 32'd25;
      advance(2);
      md_resultRDY = 1'b0;
      sb.push_back('{5'd2, 32'd3});
      issue(1'b0, 32'd9, 32'd3, 5'd2);
      advance(4);
      md_resultRDY = 1'b1; md_result = 32'd3;
      tick();
      md_resultRDY = 1'b0;
      checks++;
      if (wb_valid !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'd3) begin
         errors++;
         $display("FAIL flush_next_div: got valid=%b rd=%0d data=%0d, required 1 2 3", wb_valid, wb_rd, wb_data);
      end
      tick();
   endtask

   task automatic test_flush_idle_and_done();
      int p0 = mult_pulses + div_pulses;
      issue_valid = 1'b1; issue_is_mult = 1'b1; flush = 1'b1;
      tick();
      issue_valid = 1'b0; flush = 1'b0;
      checks++;
      if (issue_ready !== 1'b1 || md_ctrl_MULT !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle: got ready=%b mult=%b, required 1 0", issue_ready, md_ctrl_MULT);
      end
      issue(1'b1, 32'd2, 32'd2, 5'd9);
      advance(3);
      md_resultRDY = 1'b1; md_result = 32'd4;
      tick();
      md_resultRDY = 1'b0; flush = 1'b1;
      #1;
      checks++;
      if (wb_valid !== 1'b0 || (mult_pulses + div_pulses - p0) != 1) begin
         errors++;
         $display("FAIL flush_done: got wb_valid=%b pulses=%0d, required 0 and 1",
                  wb_valid, mult_pulses + div_pulses - p0);
      end
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      int mp0;
      issue(1'b1, 32'd11, 32'd13, 5'd8);
      advance(5);
      reset_n = 1'b0;
      #1;
      checks++;
      if ({issue_ready, stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid} !== 5'b10000 || md_operandA !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid: got ctrl=%b opA=%0d, required 10000 0",
                  {issue_ready, stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid}, md_operandA);
      end
      tick();
      reset_n = 1'b1;
      tick();
      mp0 = mult_pulses;
      issue(1'b1, 32'd2, 32'd3, 5'd0);
      checks++;
      if (md_ctrl_MULT !== 1'b1) begin
         errors++;
         $display("FAIL rd0_pulse: got mult=%b, required 1", md_ctrl_MULT);
      end
      advance(3);
      md_resultRDY = 1'b1; md_result = 32'd6;
      tick();
      md_resultRDY = 1'b0;
      checks++;
      if (wb_valid !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL rd0_done: got wb_valid=%b stall=%b, required 0 0", wb_valid, stall);
      end
      tick();
      checks++;
      if (issue_ready !== 1'b1 || (mult_pulses - mp0) != 1) begin
         errors++;
         $display("FAIL rd0_end: got ready=%b pulses=%0d, required 1 1", issue_ready, mult_pulses - mp0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      issue_valid = 1'b0; issue_is_mult = 1'b0; flush = 1'b0;
      issue_opA = '0; issue_opB = '0; issue_rd = '0;
      md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
      test_reset();
      test_mult_basic();
      test_div_exception();
      test_stale_ready();
      test_timeout();
      test_flush();
      test_flush_idle_and_done();
      test_reset_mid_op();
      advance(2);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending writebacks, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
